truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/gate_check_pkg.sv | 36 +++
 rtl/gate_ref_model.sv | 16 +
 rtl/truth_table_checker.sv | 108 ++++++++++
 tb/tb_truth_table_checker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared FSM state, gate function codes and expected-output function
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] GATE_AND  = 2'd0;
    localparam logic [1:0] GATE_OR   = 2'd1;
    localparam logic [1:0] GATE_XOR  = 2'd2;
    localparam logic [1:0] GATE_NAND = 2'd3;

    localparam int          NUM_VECTORS = 4;
    localparam logic [1:0]  LAST_INDEX  = 2'd3;
    localparam logic [2:0]  ERR_MAX     = 3'd4;

    function automatic logic gate_expected(
        input logic [1:0] fn,
        input logic       a,
        input logic       b
    );
        logic r;
        case (fn)
            GATE_AND:  r = a & b;
            GATE_OR:   r = a | b;
            GATE_XOR:  r = a ^ b;
            GATE_NAND: r = ~(a & b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden output of the selected 2-input gate
module gate_ref_model
    import gate_check_pkg::*;
#(
    parameter int GATE_FN = 0
) (
    input  logic a,
    input  logic b,
    output logic expected
);

    localparam logic [1:0] FN_CODE = 2'(GATE_FN);

    assign expected = gate_expected(FN_CODE, a, b);

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - walks all four input vectors through a 2-input gate and scores its output
module truth_table_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int GATE_FN       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] vec_idx;
    logic [3:0] settle_cnt;
    logic       expected;
    logic       mismatch;
    logic [2:0] err_inc;

    gate_ref_model #(
        .GATE_FN (GATE_FN)
    ) u_ref (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    assign mismatch = (y != expected);
    assign err_inc  = (err_count == ERR_MAX) ? ERR_MAX : err_count + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec_idx    <= 2'd0;
            settle_cnt <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        vec_idx    <= 2'd0;
                        settle_cnt <= CNT_LOAD;
                        a          <= 1'b0;
                        b          <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 3'd0;
                        fail_vec   <= 4'd0;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        fail_vec  <= fail_vec | (4'b0001 << vec_idx);
                    end
                    if (vec_idx == LAST_INDEX) begin
                        // The final sample's own mismatch must count toward pass.
                        state   <= ST_DONE;
                        vec_idx <= 2'd0;
                        a       <= 1'b0;
                        b       <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == 3'd0) && !mismatch;
                    end else begin
                        state      <= ST_SETTLE;
                        vec_idx    <= vec_idx + 2'd1;
                        {a, b}     <= vec_idx + 2'd1;
                        settle_cnt <= CNT_LOAD;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - randomized self-checking bench for truth_table_checker
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s  [2];
    logic       y_s      [2];
    logic       a_s      [2];
    logic       b_s      [2];
    logic       busy_s   [2];
    logic       done_s   [2];
    logic       pass_s   [2];
    logic [2:0] err_s    [2];
    logic [3:0] fail_s   [2];

    // Gate-under-check behaviour as a truth table: bit k is y for {a,b}=k.
    logic [3:0] y_tab    [2];
    logic [3:0] fn_tab   [2];
    int         s_cyc    [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign y_s[0] = y_tab[0][{a_s[0], b_s[0]}];
    assign y_s[1] = y_tab[1][{a_s[1], b_s[1]}];

    truth_table_checker #(.SETTLE_CYCLES(2), .GATE_FN(0)) u_dut_and (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .y(y_s[0]),
        .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_count(err_s[0]), .fail_vec(fail_s[0])
    );

    truth_table_checker #(.SETTLE_CYCLES(1), .GATE_FN(3)) u_dut_nand (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .y(y_s[1]),
        .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_count(err_s[1]), .fail_vec(fail_s[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_busy"}, busy_s[d], 0);
        check({tag, "_done"}, done_s[d], 0);
        check({tag, "_pass"}, pass_s[d], 0);
        check({tag, "_err"},  err_s[d],  0);
        check({tag, "_fail"}, fail_s[d], 0);
        check({tag, "_ab"},   {a_s[d], b_s[d]}, 0);
    endtask

    task automatic check_result(input int d, input logic [3:0] ytab, input string tag);
        logic [3:0] exp_fail;
        exp_fail = ytab ^ fn_tab[d];
        check({tag, "_done"}, done_s[d], 1);
        check({tag, "_busy"}, busy_s[d], 0);
        check({tag, "_err"},  err_s[d],  $countones(exp_fail));
        check({tag, "_fail"}, fail_s[d], exp_fail);
        check({tag, "_pass"}, pass_s[d], (exp_fail == 4'd0));
        check({tag, "_ab"},   {a_s[d], b_s[d]}, 0);
    endtask

    task automatic run_check(input int d, input logic [3:0] ytab, input bit extra_starts,
                             input string tag);
        int s;
        int total;
        s = s_cyc[d];
        total = 4 * (s + 1);
        y_tab[d] = ytab;
        @(negedge clk);
        start_s[d] = 1'b1;
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        check({tag, "_e0_busy"}, busy_s[d], 1);
        check({tag, "_e0_err"},  err_s[d],  0);
        check({tag, "_e0_fail"}, fail_s[d], 0);
        for (int e = 1; e <= total; e++) begin
            @(posedge clk);
            #1;
            if (e < total) begin
                check($sformatf("%s_e%0d_ab", tag, e), {a_s[d], b_s[d]}, e / (s + 1));
                check($sformatf("%s_e%0d_busy", tag, e), busy_s[d], 1);
                check($sformatf("%s_e%0d_done", tag, e), done_s[d], 0);
            end else begin
                check_result(d, ytab, tag);
            end
            start_s[d] = extra_starts && (e == 1 || e == 4);
        end
        start_s[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_result(d, ytab, {tag, "_hold"});
    endtask

    task automatic hold_run(input int d, input logic [3:0] ytab, input string tag);
        int total;
        total = 4 * (s_cyc[d] + 1);
        y_tab[d] = ytab;
        @(negedge clk);
        start_s[d] = 1'b1;
        @(posedge clk);
        repeat (total) @(posedge clk);
        #1;
        check_result(d, ytab, {tag, "_run1"});
        @(posedge clk);
        #1;
        check({tag, "_rs_busy"}, busy_s[d], 1);
        check({tag, "_rs_done"}, done_s[d], 0);
        check({tag, "_rs_err"},  err_s[d],  0);
        check({tag, "_rs_fail"}, fail_s[d], 0);
        repeat (total) @(posedge clk);
        #1;
        check_result(d, ytab, {tag, "_run2"});
        start_s[d] = 1'b0;
        @(posedge clk);
        #1;
        check_result(d, ytab, {tag, "_run2_hold"});
    endtask

    initial begin
        s_cyc[0]   = 2;
        s_cyc[1]   = 1;
        fn_tab[0]  = 4'b1000;
        fn_tab[1]  = 4'b0111;
        y_tab[0]   = 4'b1000;
        y_tab[1]   = 4'b0111;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        rst_n      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        @(negedge clk);
        rst_n = 1'b1;

        run_check(0, 4'b1000, 1'b0, "and_ok");
        run_check(0, 4'b1110, 1'b0, "or_gate");
        run_check(1, 4'b0000, 1'b0, "nand_y0");
        run_check(1, 4'b0111, 1'b1, "s1_restart");

        // Abort during vector-2 settle after vector 0 has already mismatched.
        y_tab[0] = 4'b1001;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_ab",   {a_s[0], b_s[0]}, 2);
        check("pre_rst_fail", fail_s[0], 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_check(0, 4'b1000, 1'b0, "post_rst");

        hold_run(0, 4'b1111, "held_start");

        for (int i = 0; i < 8; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            run_check(d, 4'($urandom), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
